// File: rtl/logic_cell_pkg.sv
// Shared definitions for the 3-input registered logic cell and its self-test checker.
package logic_cell_pkg;

    localparam logic [7:0]  LOGIC_CELL_TT      = 8'hF9;
    localparam int unsigned LOGIC_CELL_LATENCY = 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } chk_state_e;

    typedef struct packed {
        logic       valid;
        logic [2:0] idx;
        logic       exp_bit;
    } exp_entry_t;

    function automatic logic exp_dout(input logic a, input logic b, input logic c);
        return ~(a | b) ^ (a | c);
    endfunction

endpackage

// File: rtl/logic_exp_delay.sv
// Expectation delay line: carries {valid, idx, expected bit} in step with the cell's pipeline.
module logic_exp_delay
    import logic_cell_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  exp_entry_t in_i,
    output exp_entry_t out_o
);

    exp_entry_t stage_q [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= in_i;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign out_o = stage_q[DEPTH-1];

endmodule

// File: rtl/logic_vector_checker.sv
// Drives all 8 {A,B,C} vectors into the logic cell and compares its Dout against a golden table.
module logic_vector_checker
    import logic_cell_pkg::*;
#(
    parameter logic [7:0]  EXPECTED_TT = LOGIC_CELL_TT,
    parameter int unsigned DUT_LATENCY = LOGIC_CELL_LATENCY
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       A,
    output logic       B,
    output logic       C,
    input  logic       dut_dout,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] err_count,
    output logic [7:0] fail_vec
);

    chk_state_e state_q, state_d;
    logic [2:0] vec_idx_q, vec_idx_d;
    logic [2:0] abc_q, abc_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       pass_q, pass_d;
    logic [3:0] err_q, err_d;
    logic [7:0] fail_q, fail_d;
    exp_entry_t push, retire;
    logic       mismatch;

    // One stage beyond the cell latency so the compare sees the cell's registered Dout.
    logic_exp_delay #(
        .DEPTH (DUT_LATENCY + 1)
    ) u_exp_delay (
        .clk   (clk),
        .rst   (rst),
        .in_i  (push),
        .out_o (retire)
    );

    assign mismatch = retire.valid && (dut_dout != retire.exp_bit);

    always_comb begin
        state_d   = state_q;
        vec_idx_d = vec_idx_q;
        abc_d     = abc_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        pass_d    = pass_q;
        err_d     = err_q;
        fail_d    = fail_q;
        push      = '0;

        if (mismatch) begin
            err_d              = err_q + 4'd1;
            fail_d[retire.idx] = 1'b1;
        end

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d      = RUN;
                    vec_idx_d    = '0;
                    abc_d        = '0;
                    busy_d       = 1'b1;
                    err_d        = '0;
                    fail_d       = '0;
                    pass_d       = 1'b0;
                    push.valid   = 1'b1;
                    push.idx     = 3'd0;
                    push.exp_bit = EXPECTED_TT[0];
                end
            end
            RUN: begin
                if (vec_idx_q == 3'd7) begin
                    state_d = DRAIN;
                    abc_d   = '0;
                end else begin
                    vec_idx_d    = vec_idx_q + 3'd1;
                    abc_d        = vec_idx_d;
                    push.valid   = 1'b1;
                    push.idx     = vec_idx_d;
                    push.exp_bit = EXPECTED_TT[vec_idx_d];
                end
            end
            DRAIN: begin
                // Vector 7 is always the last entry in flight.
                if (retire.valid && (retire.idx == 3'd7)) begin
                    state_d = DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    pass_d  = (err_d == 4'd0);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            vec_idx_q <= '0;
            abc_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
            err_q     <= '0;
            fail_q    <= '0;
        end else begin
            state_q   <= state_d;
            vec_idx_q <= vec_idx_d;
            abc_q     <= abc_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            pass_q    <= pass_d;
            err_q     <= err_d;
            fail_q    <= fail_d;
        end
    end

    assign {A, B, C}  = abc_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign pass       = pass_q;
    assign err_count  = err_q;
    assign fail_vec   = fail_q;

endmodule

// File: tb/tb_logic_vector_checker.sv
// Bench for logic_vector_checker: two checkers (latency 1 and 3) each driving a modelled cell with injected faults.
module tb_logic_vector_checker;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    int   cyc = 0;
    logic [7:0] fault_mask = 8'h00;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic       a1, b1, c1, dout1, busy1, done1, pass1;
    logic [3:0] err1;
    logic [7:0] fv1;
    logic       a3, b3, c3, dout3, busy3, done3, pass3;
    logic [3:0] err3;
    logic [7:0] fv3;

    logic_vector_checker #(.EXPECTED_TT(8'hF9), .DUT_LATENCY(1)) dut1 (
        .clk(clk), .rst(rst), .start(start), .A(a1), .B(b1), .C(c1),
        .dut_dout(dout1), .busy(busy1), .done(done1), .pass(pass1),
        .err_count(err1), .fail_vec(fv1)
    );

    logic_vector_checker #(.EXPECTED_TT(8'hF9), .DUT_LATENCY(3)) dut3 (
        .clk(clk), .rst(rst), .start(start), .A(a3), .B(b3), .C(c3),
        .dut_dout(dout3), .busy(busy3), .done(done3), .pass(pass3),
        .err_count(err3), .fail_vec(fv3)
    );

    // Cell model: Dout = ~(A|B) ^ (A|C), with vector v inverted when fault_mask[v] is set.
    function automatic logic cell_fn(input logic [2:0] v, input logic [7:0] m);
        logic a, b, c;
        a = v[2];
        b = v[1];
        c = v[0];
        return (~(a | b) ^ (a | c)) ^ m[v];
    endfunction

    logic       cell1_q = 1'b0;
    logic [2:0] cell3_q = 3'b000;
    always @(posedge clk) begin
        cell1_q <= cell_fn({a1, b1, c1}, fault_mask);
        cell3_q <= {cell3_q[1:0], cell_fn({a3, b3, c3}, fault_mask)};
    end
    assign dout1 = cell1_q;
    assign dout3 = cell3_q[2];

    typedef struct packed {
        logic       pass;
        logic [3:0] err;
        logic [7:0] fv;
    } result_t;

    result_t q1[$];
    result_t q3[$];
    result_t e1, e3;
    int checks = 0;
    int failures = 0;
    int done_cnt1 = 0, done_cnt3 = 0;
    int done_cyc1 = 0, done_cyc3 = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at t=%0t", name, act, req, $time);
        end
    endtask

    // Every injected inversion is exactly one failing vector.
    function automatic result_t expect_for(input logic [7:0] m);
        result_t r;
        int n;
        n = 0;
        for (int i = 0; i < 8; i++) n += int'(m[i]);
        r.fv   = m;
        r.err  = n[3:0];
        r.pass = (n == 0);
        return r;
    endfunction

    always @(negedge clk) begin
        if (done1 === 1'b1) begin
            done_cnt1++;
            done_cyc1 = cyc;
            check("dut1_busy_at_done", busy1, 1'b0);
            if (q1.size() == 0) begin
                check("dut1_unexpected_done", done1, 1'b0);
            end else begin
                e1 = q1.pop_front();
                check("dut1_pass", pass1, e1.pass);
                check("dut1_err_count", err1, e1.err);
                check("dut1_fail_vec", fv1, e1.fv);
            end
        end
        if (done3 === 1'b1) begin
            done_cnt3++;
            done_cyc3 = cyc;
            check("dut3_busy_at_done", busy3, 1'b0);
            if (q3.size() == 0) begin
                check("dut3_unexpected_done", done3, 1'b0);
            end else begin
                e3 = q3.pop_front();
                check("dut3_pass", pass3, e3.pass);
                check("dut3_err_count", err3, e3.err);
                check("dut3_fail_vec", fv3, e3.fv);
            end
        end
    end

    task automatic check_reset_values();
        check("rst_abc1", {a1, b1, c1}, 3'd0);
        check("rst_abc3", {a3, b3, c3}, 3'd0);
        check("rst_busy1", busy1, 1'b0);
        check("rst_busy3", busy3, 1'b0);
        check("rst_done1", done1, 1'b0);
        check("rst_pass1", pass1, 1'b0);
        check("rst_err1", err1, 4'd0);
        check("rst_fv1", fv1, 8'd0);
        check("rst_err3", err3, 4'd0);
        check("rst_fv3", fv3, 8'd0);
    endtask

    // Called just after an active edge; issues one sweep and waits for both done pulses.
    task automatic sweep(input logic [7:0] m, input bit repulse);
        int s, d1, d3, n;
        result_t r;
        fault_mask = m;
        r = expect_for(m);
        q1.push_back(r);
        q3.push_back(r);
        d1 = done_cnt1;
        d3 = done_cnt3;
        start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        s = cyc;
        check("start_busy1", busy1, 1'b1);
        check("start_busy3", busy3, 1'b1);
        check("start_err_clr", err1, 4'd0);
        check("start_fv_clr", fv1, 8'd0);
        check("start_pass_clr", pass1, 1'b0);
        for (int k = 0; k < 8; k++) begin
            if (k > 0) begin
                @(posedge clk); #2;
            end
            check("abc1_seq", {a1, b1, c1}, k);
            check("abc3_seq", {a3, b3, c3}, k);
            if (repulse) start = (k == 2);
        end
        n = 7;
        while ((done_cnt1 == d1 || done_cnt3 == d3) && n < 40) begin
            @(posedge clk); #2;
            n++;
            start = repulse && (n == 8);
            if (n == 8) begin
                check("abc1_after_sweep", {a1, b1, c1}, 3'd0);
                check("abc3_after_sweep", {a3, b3, c3}, 3'd0);
            end
        end
        start = 1'b0;
        check("dut1_done_count", done_cnt1, d1 + 1);
        check("dut3_done_count", done_cnt3, d3 + 1);
        check("dut1_done_cycle", done_cyc1, s + 9);
        check("dut3_done_cycle", done_cyc3, s + 11);
        repeat (2) @(posedge clk);
        #2;
        check("dut1_err_held", err1, r.err);
        check("dut1_pass_held", pass1, r.pass);
        check("dut3_fv_held", fv3, r.fv);
    endtask

    task automatic reset_mid_sweep();
        int d1, d3;
        d1 = done_cnt1;
        d3 = done_cnt3;
        fault_mask = 8'h81;
        start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        start = 1'b1;
        @(posedge clk); #2;
        rst = 1'b0;
        start = 1'b0;
        check_reset_values();
        repeat (20) @(posedge clk);
        #2;
        check("no_done_after_rst1", done_cnt1, d1);
        check("no_done_after_rst3", done_cnt3, d3);
        check("idle_after_rst1", busy1, 1'b0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        check_reset_values();
        rst = 1'b0;
        @(posedge clk); #2;

        sweep(8'h00, 1'b0);
        sweep(8'hF9, 1'b0);
        sweep(8'h06, 1'b0);
        sweep(8'h20, 1'b0);
        sweep(8'h00, 1'b0);
        sweep(8'h00, 1'b1);
        reset_mid_sweep();
        for (int i = 0; i < 10; i++) begin
            logic [7:0] m;
            m = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 3) == 0) m = 8'h00;
            sweep(m, ($urandom_range(0, 1) == 1));
        end
        sweep(8'h00, 1'b0);

        repeat (10) @(posedge clk);
        #2;
        check("q1_drained", q1.size(), 0);
        check("q3_drained", q3.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
